idli_sqi_arb_m: RTL and testbench

- Arbitrates and sequences the shared external SQI memory, two 23LC1024-class chips wired in parallel as hi and lo byte lanes, between instruction fetch and the load/store unit.
- Each granted request becomes one complete SQI transaction (command, address, optional dummy, one 16-bit data word), driving the chip-select, clock-enable and nibble buses that reach the top-level SQI pins.
- Chips are already in SQI sequential mode before reset deassertion; that setup belongs to the boot path. This block issues no mode commands.

---
 rtl/idli_sqi_arb_m.sv | 169 ++++++++++++++++
 tb/tb_idli_sqi_arb_m.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_arb_m.sv
// Arbitrates fetch and LSU access to two parallel SQI RAMs (hi/lo byte lanes),
// turning each grant into one command/address/dummy/16-bit-data transaction.
module idli_sqi_arb_m #(
  parameter logic [7:0]  CMD_READ  = 8'h03,
  parameter logic [7:0]  CMD_WRITE = 8'h02,
  parameter logic [7:0]  ADDR_HI   = 8'h00,
  parameter int unsigned RD_DUMMY  = 2
) (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst_n,
  input  logic        i_sqi_fetch_req,
  input  logic [15:0] i_sqi_fetch_addr,
  output logic        o_sqi_fetch_ack,
  input  logic        i_sqi_lsu_req,
  input  logic        i_sqi_lsu_wr,
  input  logic [15:0] i_sqi_lsu_addr,
  input  logic [15:0] i_sqi_lsu_wdata,
  output logic        o_sqi_lsu_ack,
  output logic [15:0] o_sqi_rdata,
  output logic [1:0]  o_sqi_cs,
  output logic        o_sqi_sck,
  output logic [7:0]  o_sqi_sio,
  output logic        o_sqi_sio_oe,
  input  logic [7:0]  i_sqi_sio
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_t;

  localparam logic [2:0] DUMMY_LAST = 3'(RD_DUMMY) - 3'd1;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic        lsu_sel, lsu_sel_nx;
  logic        last_lsu;
  logic        wr, wr_nx;
  logic [15:0] addr, addr_nx;
  logic [15:0] wdata, wdata_nx;
  logic [7:0]  n0;
  logic [7:0]  opcode_nx;
  logic [23:0] addr_word;
  logic [3:0]  addr_nib;
  logic        active_nx;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + 3'd1;
    lsu_sel_nx = lsu_sel;
    wr_nx      = wr;
    addr_nx    = addr;
    wdata_nx   = wdata;
    case (state)
      IDLE: begin
        cnt_nx = 3'd0;
        if (i_sqi_fetch_req || i_sqi_lsu_req) begin
          // On a tie the requester that did not win last time gets the bus
          lsu_sel_nx = i_sqi_lsu_req && (!i_sqi_fetch_req || !last_lsu);
          wr_nx      = lsu_sel_nx && i_sqi_lsu_wr;
          addr_nx    = lsu_sel_nx ? i_sqi_lsu_addr : i_sqi_fetch_addr;
          wdata_nx   = i_sqi_lsu_wdata;
          state_nx   = CMD;
        end
      end
      CMD: if (cnt == 3'd1) begin
        state_nx = ADDR;
        cnt_nx   = 3'd0;
      end
      ADDR: if (cnt == 3'd5) begin
        state_nx = (wr || RD_DUMMY == 0) ? DATA : DUMMY;
        cnt_nx   = 3'd0;
      end
      DUMMY: if (cnt == DUMMY_LAST) begin
        state_nx = DATA;
        cnt_nx   = 3'd0;
      end
      DATA: if (cnt == 3'd1) begin
        state_nx = DONE;
        cnt_nx   = 3'd0;
      end
      DONE: begin
        state_nx = IDLE;
        cnt_nx   = 3'd0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 3'd0;
      end
    endcase

    opcode_nx = wr_nx ? CMD_WRITE : CMD_READ;
    addr_word = {ADDR_HI, addr_nx};
    case (cnt_nx)
      3'd0:    addr_nib = addr_word[23:20];
      3'd1:    addr_nib = addr_word[19:16];
      3'd2:    addr_nib = addr_word[15:12];
      3'd3:    addr_nib = addr_word[11:8];
      3'd4:    addr_nib = addr_word[7:4];
      default: addr_nib = addr_word[3:0];
    endcase
    active_nx = (state_nx == CMD) || (state_nx == ADDR) ||
                (state_nx == DUMMY) || (state_nx == DATA);
  end

  // Pin outputs are registered from the next state so they line up with it
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      state           <= IDLE;
      cnt             <= 3'd0;
      lsu_sel         <= 1'b0;
      last_lsu        <= 1'b0;
      wr              <= 1'b0;
      addr            <= 16'h0000;
      wdata           <= 16'h0000;
      n0              <= 8'h00;
      o_sqi_rdata     <= 16'h0000;
      o_sqi_cs        <= 2'b11;
      o_sqi_sck       <= 1'b0;
      o_sqi_sio       <= 8'h00;
      o_sqi_sio_oe    <= 1'b0;
      o_sqi_fetch_ack <= 1'b0;
      o_sqi_lsu_ack   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      lsu_sel <= lsu_sel_nx;
      wr      <= wr_nx;
      addr    <= addr_nx;
      wdata   <= wdata_nx;
      if (state == DONE)
        last_lsu <= lsu_sel;
      if (state == DATA && !wr) begin
        if (cnt == 3'd0)
          n0 <= i_sqi_sio;
        else
          o_sqi_rdata <= {n0[7:4], i_sqi_sio[7:4], n0[3:0], i_sqi_sio[3:0]};
      end

      o_sqi_cs        <= active_nx ? 2'b00 : 2'b11;
      o_sqi_sck       <= active_nx;
      o_sqi_fetch_ack <= (state_nx == DONE) && !lsu_sel_nx;
      o_sqi_lsu_ack   <= (state_nx == DONE) && lsu_sel_nx;

      case (state_nx)
        CMD: begin
          o_sqi_sio    <= cnt_nx[0] ? {2{opcode_nx[3:0]}} : {2{opcode_nx[7:4]}};
          o_sqi_sio_oe <= 1'b1;
        end
        ADDR: begin
          o_sqi_sio    <= {2{addr_nib}};
          o_sqi_sio_oe <= 1'b1;
        end
        DATA: begin
          if (wr_nx) begin
            o_sqi_sio    <= cnt_nx[0] ? {wdata_nx[11:8], wdata_nx[3:0]}
                                      : {wdata_nx[15:12], wdata_nx[7:4]};
            o_sqi_sio_oe <= 1'b1;
          end else begin
            o_sqi_sio    <= 8'h00;
            o_sqi_sio_oe <= 1'b0;
          end
        end
        default: begin
          o_sqi_sio    <= 8'h00;
          o_sqi_sio_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idli_sqi_arb_m.sv
// Bench for idli_sqi_arb_m: directed table rows plus randomized arbitration
// traffic, checked cycle by cycle against a nibble-level transaction model.
module tb_idli_sqi_arb_m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        fetch_req = 1'b0, lsu_req = 1'b0, lsu_wr = 1'b0;
  logic [15:0] fetch_addr = '0, lsu_addr = '0, lsu_wdata = '0;
  logic [7:0]  sio_in = '0;

  logic        fetch_ack0, lsu_ack0, sck0, oe0, fetch_ack1, lsu_ack1, sck1, oe1;
  logic [15:0] rdata0, rdata1;
  logic [1:0]  cs0, cs1;
  logic [7:0]  sio0, sio1;

  logic        fetch_ack, lsu_ack, sck, oe;
  logic [15:0] rdata;
  logic [1:0]  cs;
  logic [7:0]  sio;

  int vectors = 0;
  int miscompares = 0;
  logic last_lsu = 1'b0;

  always #5 clk = ~clk;

  assign fetch_ack = sel ? fetch_ack1 : fetch_ack0;
  assign lsu_ack   = sel ? lsu_ack1   : lsu_ack0;
  assign sck       = sel ? sck1       : sck0;
  assign oe        = sel ? oe1        : oe0;
  assign rdata     = sel ? rdata1     : rdata0;
  assign cs        = sel ? cs1        : cs0;
  assign sio       = sel ? sio1       : sio0;

  idli_sqi_arb_m dut0 (
    .i_sqi_gck(clk), .i_sqi_rst_n(rst_n),
    .i_sqi_fetch_req(fetch_req & ~sel), .i_sqi_fetch_addr(fetch_addr),
    .o_sqi_fetch_ack(fetch_ack0),
    .i_sqi_lsu_req(lsu_req & ~sel), .i_sqi_lsu_wr(lsu_wr),
    .i_sqi_lsu_addr(lsu_addr), .i_sqi_lsu_wdata(lsu_wdata),
    .o_sqi_lsu_ack(lsu_ack0), .o_sqi_rdata(rdata0), .o_sqi_cs(cs0),
    .o_sqi_sck(sck0), .o_sqi_sio(sio0), .o_sqi_sio_oe(oe0), .i_sqi_sio(sio_in)
  );

  // Second instance with no dummy cycles
  idli_sqi_arb_m #(.RD_DUMMY(0)) dut1 (
    .i_sqi_gck(clk), .i_sqi_rst_n(rst_n),
    .i_sqi_fetch_req(fetch_req & sel), .i_sqi_fetch_addr(fetch_addr),
    .o_sqi_fetch_ack(fetch_ack1),
    .i_sqi_lsu_req(lsu_req & sel), .i_sqi_lsu_wr(lsu_wr),
    .i_sqi_lsu_addr(lsu_addr), .i_sqi_lsu_wdata(lsu_wdata),
    .o_sqi_lsu_ack(lsu_ack1), .o_sqi_rdata(rdata1), .o_sqi_cs(cs1),
    .o_sqi_sck(sck1), .o_sqi_sio(sio1), .o_sqi_sio_oe(oe1), .i_sqi_sio(sio_in)
  );

  typedef struct {
    bit          do_rst;
    bit          sel;
    logic        freq, lreq, lwr;
    logic [15:0] faddr, laddr, wdata;
    logic [7:0]  rd0, rd1;
    logic        exp_lsu;
    logic [15:0] exp_rdata;
    bit          scramble;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    logic       oe;
    bit         chk;
    int         rd;
  } slot_t;

  function automatic logic [15:0] combine(input logic [7:0] a, input logic [7:0] b);
    return {a[7:4], b[7:4], a[3:0], b[3:0]};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_output({tag, "_cs"}, 32'(cs), 32'(2'b11));
    check_output({tag, "_sck"}, 32'(sck), 32'd0);
    check_output({tag, "_oe"}, 32'(oe), 32'd0);
    check_output({tag, "_fack"}, 32'(fetch_ack), 32'd0);
    check_output({tag, "_lack"}, 32'(lsu_ack), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    fetch_req = 1'b0;
    lsu_req = 1'b0;
    last_lsu = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at the falling edge of the grant (IDLE) cycle with requests set;
  // returns at the falling edge of the IDLE cycle that follows DONE.
  task automatic apply_stimulus(input logic is_lsu, input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [7:0] rd0,
                                input logic [7:0] rd1, input int dummy, input bit scramble,
                                input logic [15:0] exp_rdata);
    slot_t seq[$];
    logic [7:0] op;
    logic [23:0] aw;
    logic [3:0] nb;
    op = wr ? 8'h02 : 8'h03;
    aw = {8'h00, addr};
    seq.push_back('{{2{op[7:4]}}, 1'b1, 1'b1, 0});
    seq.push_back('{{2{op[3:0]}}, 1'b1, 1'b1, 0});
    for (int k = 0; k < 6; k++) begin
      nb = aw[23 - 4*k -: 4];
      seq.push_back('{{2{nb}}, 1'b1, 1'b1, 0});
    end
    if (wr) begin
      seq.push_back('{{wdata[15:12], wdata[7:4]}, 1'b1, 1'b1, 0});
      seq.push_back('{{wdata[11:8], wdata[3:0]}, 1'b1, 1'b1, 0});
    end else begin
      for (int k = 0; k < dummy; k++) seq.push_back('{8'h00, 1'b0, 1'b0, 0});
      seq.push_back('{8'h00, 1'b0, 1'b0, 1});
      seq.push_back('{8'h00, 1'b0, 1'b0, 2});
    end

    for (int i = 0; i < seq.size(); i++) begin
      @(negedge clk);
      check_output($sformatf("xfer%0d_cs", i + 1), 32'(cs), 32'(2'b00));
      check_output($sformatf("xfer%0d_sck", i + 1), 32'(sck), 32'd1);
      check_output($sformatf("xfer%0d_oe", i + 1), 32'(oe), 32'(seq[i].oe));
      if (seq[i].chk)
        check_output($sformatf("xfer%0d_sio", i + 1), 32'(sio), 32'(seq[i].b));
      check_output($sformatf("xfer%0d_acks", i + 1), 32'({fetch_ack, lsu_ack}), 32'd0);
      sio_in = (seq[i].rd == 1) ? rd0 : (seq[i].rd == 2) ? rd1 : 8'($urandom);
      if (scramble && i == 0) begin
        lsu_addr   = ~lsu_addr;
        lsu_wdata  = ~lsu_wdata;
        fetch_addr = ~fetch_addr;
      end
    end

    @(negedge clk);
    check_output($sformatf("done%0d_cs", seq.size() + 1), 32'(cs), 32'(2'b11));
    check_output("done_sck", 32'(sck), 32'd0);
    check_output("done_fetch_ack", 32'(fetch_ack), 32'(!is_lsu));
    check_output("done_lsu_ack", 32'(lsu_ack), 32'(is_lsu));
    if (!wr) check_output("done_rdata", 32'(rdata), 32'(exp_rdata));
    @(negedge clk);
    check_quiet("gap");
  endtask

  vec_t vec[8];
  logic pend_f, pend_l, win, rwr;
  logic [7:0] r0, r1;

  initial begin
    vec[0] = '{0, 0, 1, 0, 0, 16'h1234, 16'h0000, 16'h0000, 8'hAB, 8'hCD, 0, 16'hACBD, 0};
    vec[1] = '{0, 0, 0, 1, 1, 16'h0000, 16'h00FF, 16'hBEEF, 8'h00, 8'h00, 1, 16'h0000, 1};
    vec[2] = '{0, 0, 0, 1, 0, 16'h0000, 16'h8001, 16'h0000, 8'h5A, 8'hC3, 1, 16'h5CA3, 0};
    vec[3] = '{1, 0, 1, 1, 1, 16'h0F0F, 16'h4321, 16'hCAFE, 8'h12, 8'h34, 1, 16'h0000, 0};
    vec[4] = '{0, 0, 1, 1, 1, 16'h0F0F, 16'h4321, 16'hCAFE, 8'h12, 8'h34, 0, 16'h1324, 0};
    vec[5] = '{0, 0, 1, 1, 1, 16'h0F0F, 16'h4321, 16'hCAFE, 8'h12, 8'h34, 1, 16'h0000, 0};
    vec[6] = '{0, 0, 1, 1, 1, 16'h0F0F, 16'h4321, 16'hCAFE, 8'hE1, 8'h2D, 0, 16'hE21D, 0};
    vec[7] = '{0, 1, 1, 0, 0, 16'h7E81, 16'h0000, 16'h0000, 8'h96, 8'h0F, 0, 16'h906F, 0};

    repeat (2) @(negedge clk);
    check_quiet("rst");
    check_output("rst_sio", 32'(sio), 32'd0);
    check_output("rst_rdata", 32'(rdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of an address phase aborts silently
    fetch_addr = 16'h2222;
    fetch_req = 1'b1;
    repeat (4) @(negedge clk);
    check_output("abort_pre_cs", 32'(cs), 32'(2'b00));
    rst_n = 1'b0;
    #1;
    check_quiet("abort");
    fetch_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_quiet($sformatf("post_abort%0d", i));
    end

    for (int v = 0; v < 8; v++) begin
      if (vec[v].do_rst) apply_reset();
      sel        = vec[v].sel;
      fetch_req  = vec[v].freq;
      lsu_req    = vec[v].lreq;
      lsu_wr     = vec[v].lwr;
      fetch_addr = vec[v].faddr;
      lsu_addr   = vec[v].laddr;
      lsu_wdata  = vec[v].wdata;
      $display("[TB] vector %0d", v);
      apply_stimulus(vec[v].exp_lsu, vec[v].exp_lsu && vec[v].lwr,
                     vec[v].exp_lsu ? vec[v].laddr : vec[v].faddr, vec[v].wdata,
                     vec[v].rd0, vec[v].rd1, vec[v].sel ? 0 : 2, vec[v].scramble,
                     vec[v].exp_rdata);
    end

    sel = 1'b0;
    apply_reset();
    pend_f = 1'b0;
    pend_l = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (!pend_f && $urandom_range(1, 0) == 1) begin
        pend_f = 1'b1;
        fetch_addr = 16'($urandom);
      end
      if (!pend_l && ($urandom_range(1, 0) == 1 || !pend_f)) begin
        pend_l = 1'b1;
        lsu_wr = 1'($urandom);
        lsu_addr = 16'($urandom);
        lsu_wdata = 16'($urandom);
      end
      fetch_req = pend_f;
      lsu_req = pend_l;
      win = pend_l && (!pend_f || !last_lsu);
      rwr = win && lsu_wr;
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      apply_stimulus(win, rwr, win ? lsu_addr : fetch_addr, lsu_wdata, r0, r1, 2, 0,
                     combine(r0, r1));
      last_lsu = win;
      if (win) pend_l = 1'b0;
      else pend_f = 1'b0;
    end
    fetch_req = 1'b0;
    lsu_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
